sar_sequencer: RTL and testbench
================================

# sar_sequencer

Successive-approximation conversion sequencer for the PWM-DAC + comparator ADC. It drives the trial code into the PWM stage and waits a programmable settling time so the RC-filtered PWM output can settle. It then samples the external comparator through a synchronizer and resolves one bit per step, MSB first. It sits directly upstream of the PWM block and produces a registered conversion result with a one-cycle valid strobe for display and downstream logic.

## Interface

Parameters:
- BITS, default 8: resolution; width of the trial code and the result.
- SETTLE_CYCLES, default 1024: clock cycles the trial code is held before each comparator decision. Legal minimum is 3.

Ports:
- CLOCK_50  input  1  system clock; the only clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  conversion request, sampled only in IDLE.
- compare  input  1  asynchronous comparator output; 1 means the analog input is above the current DAC level.
- dac_code  output  BITS  trial code fed to the PWM stage.
- result  output  BITS  last completed conversion.
- result_valid  output  1  one-cycle strobe when result updates.
- busy  output  1  high while a conversion is in progress.

## Operation

- Compare synchronizer: two flops, both reset to 0. All decisions use the output of the second flop (cmp_s).
- States:
  - IDLE: busy=0. When start=1 at an edge: dac_code <= 1<<(BITS-1), idx <= BITS-1, cnt <= 0, go to SETTLE.
  - SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to DECIDE.
  - DECIDE, one cycle:
    - If cmp_s==0, clear bit idx of dac_code; otherwise keep it.
    - If idx>0: set bit idx-1, idx <= idx-1, cnt <= 0, go to SETTLE.
    - If idx==0: result <= final code, result_valid <= 1, go to IDLE.
- Outside the final decision, result_valid is driven to 0 on every cycle.
- In IDLE, dac_code holds the last final code, so the PWM keeps outputting the converted level.
- Bits already resolved are never modified later in the same conversion.
- All arithmetic is unsigned. cnt is sized with $clog2(SETTLE_CYCLES) bits and idx with $clog2(BITS) bits, each with a minimum of 1 bit.

## Timing

- Reset values: dac_code=0, result=0, result_valid=0, busy=0, state IDLE, cnt=0, idx=0, synchronizer flops 0.
- Reset asserted mid-conversion aborts immediately to the reset values. No result_valid is produced for the aborted conversion.
- Per-bit time is SETTLE_CYCLES+1 cycles.
- busy is high for exactly BITS*(SETTLE_CYCLES+1) cycles, starting the cycle after start is sampled.
- result_valid is high for the single cycle immediately after busy falls. That cycle is an IDLE cycle.
- start is ignored while busy=1, with no queueing.
- start held high: the IDLE/valid cycle samples start, so back-to-back conversions occur with a period of BITS*(SETTLE_CYCLES+1)+1 cycles.
- The comparator decision reflects compare as it was at least 2 cycles before DECIDE. SETTLE_CYCLES ≥ 3 guarantees it reflects the current trial code.

## Configuration

- SAR_AUTORESTART_EN defined:
  - The sequencer is free-running. Every IDLE cycle behaves as if start=1, including the first cycle after reset release.
  - The start input is ignored.
  - The conversion period is BITS*(SETTLE_CYCLES+1)+1 cycles.
- SAR_AUTORESTART_EN undefined:
  - Conversions begin only when start is sampled high in IDLE, as described above.

## Test plan

Unless noted, the bench uses BITS=8 and SETTLE_CYCLES=4, so busy lasts 40 cycles. The comparator model is compare = (vin > dac_code), where vin is 9-bit.

- vin=0x80, single start pulse:
  - dac_code steps through 0x80,0x40,0x60,0x70,0x78,0x7C,0x7E,0x7F, each held 5 cycles.
  - result=0x7F, with result_valid high for exactly 1 cycle, 40 cycles after busy rises.
- Endpoints:
  - vin=0x000 gives result 0x00.
  - vin=0x0A6 gives result 0xA5.
  - vin=0x100 gives result 0xFF.
- start pulsed at cycle 10 of a busy conversion: it is ignored; exactly one result_valid occurs, and the result is unaffected.
- rst driven low at cycle 20 of a conversion:
  - All outputs are 0 asynchronously and no result_valid is produced.
  - After release, a new start with vin=0x0A6 gives 0xA5.
- start held high with vin=0x033 and then 0x0C1: result_valid strobes every 41 cycles, giving results 0x32 and then 0xC0.
- Built with SAR_AUTORESTART_EN defined and start tied to 0: the first result_valid occurs at cycle 41 after reset release, then repeats every 41 cycles.

Source files
------------

// File: rtl/sar_sequencer.sv
// sar_sequencer: successive-approximation sequencer driving a PWM-DAC trial code and sampling an external comparator.
// Optional SAR_AUTORESTART_EN: free-running conversions; the start input is ignored.
module sar_sequencer #(
  parameter int unsigned BITS          = 8,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic            CLOCK_50,
  input  logic            rst,
  input  logic            start,
  input  logic            compare,
  output logic [BITS-1:0] dac_code,
  output logic [BITS-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  localparam int unsigned     CNTW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned     IDXW     = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(BITS - 1);
  localparam logic [BITS-1:0] MSB_ONLY = BITS'(1) << (BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE
  } state_t;

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [IDXW-1:0] idx_q;
  logic [BITS-1:0] dac_q;
  logic [BITS-1:0] result_q;
  logic            valid_q;
  logic            busy_q;
  logic            cmp_meta_q;
  logic            cmp_s_q;
  logic [BITS-1:0] dac_d;
  logic            go;

`ifdef SAR_AUTORESTART_EN
  logic unused_start;
  assign unused_start = start;
  assign go           = 1'b1;
`else
  assign go = start;
`endif

  // Resolve bit idx from the synchronized comparator and arm the next lower trial bit.
  always_comb begin
    dac_d = dac_q;
    for (int unsigned b = 0; b < BITS; b++) begin
      if ((IDXW'(b) == idx_q) && !cmp_s_q) dac_d[b] = 1'b0;
      if ((idx_q != '0) && (IDXW'(b) == (idx_q - IDXW'(1)))) dac_d[b] = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      dac_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= compare;
      cmp_s_q    <= cmp_meta_q;
      valid_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            dac_q   <= MSB_ONLY;
            idx_q   <= IDX_TOP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNT_LAST) state_q <= DECIDE;
        end
        DECIDE: begin
          dac_q <= dac_d;
          if (idx_q == '0) begin
            result_q <= dac_d;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            idx_q   <= idx_q - IDXW'(1);
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dac_code     = dac_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Self-checking bench for sar_sequencer (BITS=8, SETTLE_CYCLES=4) with a vin-vs-DAC comparator model.
module tb_sar_sequencer;

  localparam int unsigned BITS     = 8;
  localparam int unsigned SETTLE   = 4;
  localparam int          BUSY_LEN = BITS * (SETTLE + 1);
  localparam int          PERIOD   = BUSY_LEN + 1;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic       start;
  logic       compare;
  logic [7:0] dac_code;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic [8:0] vin;

  int tests = 0;
  int fails = 0;
  logic [7:0] trace [0:BUSY_LEN-1];

  typedef struct {
    logic [8:0] vin;
    logic [7:0] res;
  } vec_t;

  sar_sequencer #(.BITS(BITS), .SETTLE_CYCLES(SETTLE)) dut (
    .CLOCK_50     (CLOCK_50),
    .rst          (rst),
    .start        (start),
    .compare      (compare),
    .dac_code     (dac_code),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign compare = (vin > {1'b0, dac_code});

  // A SAR against "vin > dac" converges on the largest code strictly below vin.
  function automatic logic [7:0] ref_result(input logic [8:0] v);
    if (v == 9'd0) return 8'h00;
    if (v > 9'd256) return 8'hFF;
    return 8'(v - 9'd1);
  endfunction

  // Trial code while resolving step k: final bits above the trial bit, plus the trial bit.
  function automatic logic [7:0] ref_trial(input logic [7:0] res, input int k);
    logic [7:0] hi_mask;
    hi_mask = 8'hFF << (8 - k);
    return (res & hi_mask) | (8'h80 >> k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_conv(input logic [8:0] v, input logic [7:0] expv, input int poke_at,
                          input string tag);
    int n;
    int stray;
    int bad;
    @(negedge CLOCK_50);
    vin   = v;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check({tag, " busy rise"}, busy, 1);
    n     = 0;
    stray = 0;
    while (busy && n < 200) begin
      if (result_valid) stray++;
      if (n < BUSY_LEN) trace[n] = dac_code;
      n++;
      start = (n == poke_at);
      @(negedge CLOCK_50);
    end
    start = 1'b0;
    check({tag, " busy length"}, n, BUSY_LEN);
    check({tag, " valid during busy"}, stray, 0);
    check({tag, " valid strobe"}, result_valid, 1);
    check({tag, " result"}, result, expv);
    bad = 0;
    for (int k = 0; k < BITS; k++)
      for (int j = 0; j <= SETTLE; j++)
        if (trace[k*(SETTLE+1)+j] !== ref_trial(expv, k)) bad++;
    check({tag, " trial sequence errors"}, bad, 0);
    @(negedge CLOCK_50);
    check({tag, " valid one cycle"}, result_valid, 0);
    check({tag, " dac holds result"}, dac_code, expv);
    check({tag, " idle after"}, busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef SAR_AUTORESTART_EN
  initial begin
    int n;
    logic [8:0] v;
    rst   = 1'b0;
    start = 1'b0;
    vin   = 9'h0A6;
    repeat (3) @(negedge CLOCK_50);
    check("reset busy", busy, 0);
    check("reset dac", dac_code, 0);
    rst = 1'b1;
    n = 0;
    while (!result_valid && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("auto first valid cycle", n, PERIOD);
    check("auto first result", result, 8'hA5);
    for (int r = 0; r < 4; r++) begin
      v   = 9'($urandom_range(0, 300));
      vin = v;
      n   = 0;
      do begin
        @(negedge CLOCK_50);
        n++;
      end while (!result_valid && n < 200);
      check("auto period", n, PERIOD);
      check("auto result", result, ref_result(v));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
`else
  initial begin
    vec_t vecs [8];
    logic [7:0] steps [8];
    int n;
    int stray;
    logic [8:0] v;

    vecs[0] = '{9'h000, 8'h00};
    vecs[1] = '{9'h0A6, 8'hA5};
    vecs[2] = '{9'h100, 8'hFF};
    vecs[3] = '{9'h033, 8'h32};
    vecs[4] = '{9'h0C1, 8'hC0};
    vecs[5] = '{9'h001, 8'h00};
    vecs[6] = '{9'h0FF, 8'hFE};
    vecs[7] = '{9'h1FF, 8'hFF};
    steps   = '{8'h80, 8'h40, 8'h60, 8'h70, 8'h78, 8'h7C, 8'h7E, 8'h7F};

    rst   = 1'b0;
    start = 1'b0;
    vin   = 9'h000;
    repeat (2) @(negedge CLOCK_50);
    check("reset dac_code", dac_code, 0);
    check("reset result", result, 0);
    check("reset result_valid", result_valid, 0);
    check("reset busy", busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check("idle without start", busy, 0);

    run_conv(9'h080, 8'h7F, 0, "vin80");
    for (int k = 0; k < 8; k++)
      check($sformatf("vin80 step %0d", k), trace[k*(SETTLE+1)], steps[k]);

    for (int i = 0; i < 8; i++)
      run_conv(vecs[i].vin, vecs[i].res, 0, $sformatf("vec%0d", i));

    run_conv(9'h0A6, 8'hA5, 10, "start ignored");
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      if (result_valid || busy) stray++;
    end
    check("no queued conversion", stray, 0);

    @(negedge CLOCK_50);
    vin   = 9'h0A6;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (19) @(negedge CLOCK_50);
    check("pre-abort busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("abort dac_code", dac_code, 0);
    check("abort result", result, 0);
    check("abort busy", busy, 0);
    check("abort valid", result_valid, 0);
    stray = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (result_valid || busy) stray++;
    end
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      if (result_valid || busy) stray++;
    end
    check("no valid after abort", stray, 0);
    run_conv(9'h0A6, 8'hA5, 0, "post-abort");

    @(negedge CLOCK_50);
    vin   = 9'h033;
    start = 1'b1;
    n = 0;
    while (!result_valid && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("held start first latency", n, PERIOD);
    check("held start result 1", result, 8'h32);
    vin = 9'h0C1;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!result_valid && n < 200);
    start = 1'b0;
    check("held start period", n, PERIOD);
    check("held start result 2", result, 8'hC0);
    repeat (2) @(negedge CLOCK_50);
    check("held start released", busy, 0);

    for (int r = 0; r < 6; r++) begin
      v = 9'($urandom_range(0, 300));
      run_conv(v, ref_result(v), 0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
`endif

endmodule
